// File: rtl/cnv_pkg.sv
// Shared types and defaults for the convolution PE partial-sum accumulators.
package cnv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ACC   = 2'd2,
    ST_DRAIN = 2'd3
  } cnv_state_e;

  localparam int MAC_WIDTH_DEF  = 19;
  localparam int PSUM_WIDTH_DEF = 23;
  localparam int LEN_ROW_DEF    = 16;

  localparam logic [PSUM_WIDTH_DEF-1:0] PSUM_MAX_DEF = {1'b0, {(PSUM_WIDTH_DEF-1){1'b1}}};
  localparam logic [PSUM_WIDTH_DEF-1:0] PSUM_MIN_DEF = {1'b1, {(PSUM_WIDTH_DEF-1){1'b0}}};

  // A one-bit-wider signed sum overflowed when its top two bits disagree.
  function automatic logic signed_ovf(input logic guard_bit, input logic msb);
    return guard_bit ^ msb;
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// Combinational signed add of a narrower MAC term into a partial sum,
// with saturate-or-wrap selection and an overflow flag.
module psum_sat_add
  import cnv_pkg::*;
#(
  parameter int ACC_W = PSUM_WIDTH_DEF,
  parameter int ADD_W = MAC_WIDTH_DEF
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [ADD_W-1:0] add_i,
  input  logic             sat_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] add_ext;
  logic [ACC_W:0] sum_ext;

  assign acc_ext = {acc_i[ACC_W-1], acc_i};
  assign add_ext = {{(ACC_W+1-ADD_W){add_i[ADD_W-1]}}, add_i};
  assign sum_ext = acc_ext + add_ext;
  assign ovf_o   = signed_ovf(sum_ext[ACC_W], sum_ext[ACC_W-1]);

  always_comb begin
    sum_o = sum_ext[ACC_W-1:0];
    if (ovf_o && sat_i) begin
      sum_o = sum_ext[ACC_W] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/cnv_row_acc.sv
// Row partial-sum accumulator: optional preload, per-pixel MAC accumulate,
// then a registered drain stream, all walking the row in descending address.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for start; config latched on the accepting edge
//   ST_LOAD  | accepting preload beats into row[addr], addr counts down
//   ST_ACC   | accepting MAC beats, row[addr] += mac_sum, addr counts down
//   ST_DRAIN | streaming row[addr] out, done pulses after the last beat
module cnv_row_acc
  import cnv_pkg::*;
#(
  parameter int MAC_WIDTH  = MAC_WIDTH_DEF,
  parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
  parameter int LEN_ROW    = LEN_ROW_DEF,
  parameter int AW         = $clog2(LEN_ROW)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW:0]           cfg_len,
  input  logic                  cfg_first,
  input  logic                  cfg_sat,
  output logic                  busy,
  output logic                  done,
  input  logic                  psum_in_vld,
  output logic                  psum_in_rdy,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  input  logic                  mac_vld,
  output logic                  mac_rdy,
  input  logic [MAC_WIDTH-1:0]  mac_sum,
  input  logic                  mac_last,
  output logic                  psum_out_vld,
  input  logic                  psum_out_rdy,
  output logic [PSUM_WIDTH-1:0] psum_out,
  output logic                  psum_out_last,
  output logic                  ovf,
  output logic                  err_last
);

  cnv_state_e            state_q;
  logic [AW-1:0]         addr_q;
  logic [AW-1:0]         last_addr_q;
  logic                  sat_q;
  logic                  ovf_q;
  logic                  err_q;
  logic                  done_q;
  logic                  out_vld_q;
  logic                  out_last_q;
  logic [PSUM_WIDTH-1:0] out_q;
  logic [PSUM_WIDTH-1:0] row_q [LEN_ROW];

  logic [AW:0]           len_d;
  logic [AW-1:0]         last_addr_d;
  logic [AW-1:0]         addr_dec;
  logic [PSUM_WIDTH-1:0] acc_sum;
  logic                  acc_ovf;

  // A zero length behaves as one; anything above the buffer depth is clamped.
  always_comb begin
    len_d = cfg_len;
    if (cfg_len == '0) begin
      len_d = (AW+1)'(1);
    end else if (cfg_len > (AW+1)'(LEN_ROW)) begin
      len_d = (AW+1)'(LEN_ROW);
    end
  end

  assign last_addr_d = AW'(len_d - (AW+1)'(1));
  assign addr_dec    = addr_q - AW'(1);

  psum_sat_add #(
    .ACC_W (PSUM_WIDTH),
    .ADD_W (MAC_WIDTH)
  ) u_add (
    .acc_i (row_q[addr_q]),
    .add_i (mac_sum),
    .sat_i (sat_q),
    .sum_o (acc_sum),
    .ovf_o (acc_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= AW'(LEN_ROW-1);
      last_addr_q <= AW'(LEN_ROW-1);
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_q       <= '0;
      for (int i = 0; i < LEN_ROW; i++) begin
        row_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The done cycle itself must not accept a new start.
          if (start && !done_q) begin
            last_addr_q <= last_addr_d;
            addr_q      <= last_addr_d;
            sat_q       <= cfg_sat;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            if (cfg_first) begin
              for (int i = 0; i < LEN_ROW; i++) begin
                if (AW'(i) <= last_addr_d) begin
                  row_q[i] <= '0;
                end
              end
              state_q <= ST_ACC;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (psum_in_vld) begin
            row_q[addr_q] <= psum_in;
            if (addr_q == '0) begin
              state_q <= ST_ACC;
              addr_q  <= last_addr_q;
            end else begin
              addr_q <= addr_dec;
            end
          end
        end

        ST_ACC: begin
          if (mac_vld) begin
            row_q[addr_q] <= acc_sum;
            if (acc_ovf) begin
              ovf_q <= 1'b1;
            end
            if (mac_last != (addr_q == '0)) begin
              err_q <= 1'b1;
            end
            if (addr_q == '0) begin
              state_q <= ST_DRAIN;
              addr_q  <= last_addr_q;
            end else begin
              addr_q <= addr_dec;
            end
          end
        end

        ST_DRAIN: begin
          if (!out_vld_q) begin
            out_vld_q  <= 1'b1;
            out_q      <= row_q[addr_q];
            out_last_q <= (addr_q == '0);
          end else if (psum_out_rdy) begin
            if (out_last_q) begin
              out_vld_q <= 1'b0;
              state_q   <= ST_IDLE;
              done_q    <= 1'b1;
            end else begin
              addr_q     <= addr_dec;
              out_q      <= row_q[addr_dec];
              out_last_q <= (addr_q == AW'(1));
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign psum_in_rdy   = (state_q == ST_LOAD);
  assign mac_rdy       = (state_q == ST_ACC);
  assign done          = done_q;
  assign psum_out_vld  = out_vld_q;
  assign psum_out      = out_q;
  assign psum_out_last = out_last_q;
  assign ovf           = ovf_q;
  assign err_last      = err_q;

endmodule

// File: tb/tb_cnv_row_acc.sv
// Scoreboarded bench for cnv_row_acc: beat-order arithmetic model feeds an
// expectation queue, a negedge monitor checks every drain handshake.
module tb_cnv_row_acc;

  localparam longint PMAX = 64'sd4194303;
  localparam longint PMIN = -64'sd4194304;
  localparam longint PMOD = 64'sd8388608;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  cfg_len = '0;
  logic        cfg_first = 1'b0;
  logic        cfg_sat = 1'b0;
  logic        busy, done;
  logic        psum_in_vld = 1'b0;
  logic        psum_in_rdy;
  logic [22:0] psum_in = '0;
  logic        mac_vld = 1'b0;
  logic        mac_rdy;
  logic [18:0] mac_sum = '0;
  logic        mac_last = 1'b0;
  logic        psum_out_vld;
  logic        psum_out_rdy = 1'b1;
  logic [22:0] psum_out;
  logic        psum_out_last;
  logic        ovf, err_last;

  cnv_row_acc #(.MAC_WIDTH(19), .PSUM_WIDTH(23), .LEN_ROW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .cfg_first(cfg_first), .cfg_sat(cfg_sat), .busy(busy), .done(done),
    .psum_in_vld(psum_in_vld), .psum_in_rdy(psum_in_rdy), .psum_in(psum_in),
    .mac_vld(mac_vld), .mac_rdy(mac_rdy), .mac_sum(mac_sum), .mac_last(mac_last),
    .psum_out_vld(psum_out_vld), .psum_out_rdy(psum_out_rdy), .psum_out(psum_out),
    .psum_out_last(psum_out_last), .ovf(ovf), .err_last(err_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] d;
    bit          last;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     n_drained = 0;
  longint pre_v [16];
  longint mac_v [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (bound expired or unexpected event)", nm);
  endtask

  // Monitor: pops the scoreboard on every drain handshake, checks stall hold.
  bit          prev_stall = 1'b0;
  logic [22:0] prev_d;
  logic        prev_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_vld", 64'(psum_out_vld), 64'(1));
        chk("hold_data", 64'(psum_out), 64'(prev_d));
        chk("hold_last", 64'(psum_out_last), 64'(prev_last));
      end
      if (psum_out_vld && psum_out_rdy) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_drain_beat");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("drain_data", 64'(psum_out), 64'(e.d));
          chk("drain_last", 64'(psum_out_last), 64'(e.last));
        end
        n_drained++;
      end
      prev_stall = psum_out_vld && !psum_out_rdy;
      prev_d     = psum_out;
      prev_last  = psum_out_last;
    end
  end

  // Reference model: beat k lands on the k-th drained word.
  task automatic build_expect(input int len, input bit first, input bit sat, output bit o);
    longint s;
    exp_t   e;
    o = 1'b0;
    for (int k = 0; k < len; k++) begin
      s = (first ? 64'sd0 : pre_v[k]) + mac_v[k];
      if (s > PMAX || s < PMIN) begin
        o = 1'b1;
        if (sat) s = (s > PMAX) ? PMAX : PMIN;
        else     s = (s > PMAX) ? s - PMOD : s + PMOD;
      end
      e.d    = 23'(s);
      e.last = (k == len - 1);
      exp_q.push_back(e);
    end
  endtask

  // All driving below happens at negedge unless noted.
  task automatic send_start(input int clen, input bit first, input bit sat);
    cfg_len   = 5'(clen);
    cfg_first = first;
    cfg_sat   = sat;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic feed_psum(input longint v, input int gap_max);
    int t;
    repeat ($urandom_range(0, gap_max)) begin
      psum_in_vld = 1'b0;
      @(negedge clk);
    end
    psum_in_vld = 1'b1;
    psum_in     = 23'(v);
    t = 0;
    while (!psum_in_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!psum_in_rdy) fail_now("psum_in_timeout");
    @(negedge clk);
    psum_in_vld = 1'b0;
  endtask

  task automatic feed_mac(input longint v, input bit lst, input int gap_max, input bit poke);
    int t;
    repeat ($urandom_range(0, gap_max)) begin
      mac_vld = 1'b0;
      @(negedge clk);
    end
    mac_vld  = 1'b1;
    mac_sum  = 19'(v);
    mac_last = lst;
    if (poke) begin
      cfg_len   = 5'd1;
      cfg_first = ~cfg_first;
      cfg_sat   = ~cfg_sat;
      start     = 1'b1;
    end
    t = 0;
    while (!mac_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!mac_rdy) fail_now("mac_timeout");
    @(negedge clk);
    mac_vld  = 1'b0;
    mac_last = 1'b0;
    start    = 1'b0;
  endtask

  task automatic do_op(input int clen, input bit first, input bit sat, input int last_beat,
                       input int gap_max, input int stall_at, input bit rdy_rand,
                       input bit poke_busy, input bit poke_done);
    int  len;
    int  stall_left;
    bit  exp_ovf;
    bit  got_done;
    len = (clen == 0) ? 1 : clen;
    build_expect(len, first, sat, exp_ovf);
    n_drained  = 0;
    stall_left = 5;
    send_start(clen, first, sat);
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("stage_rdy_after_start", 64'(first ? mac_rdy : psum_in_rdy), 64'(1));
    if (!first) begin
      for (int k = 0; k < len; k++) feed_psum(pre_v[k], gap_max);
    end
    for (int k = 0; k < len; k++) begin
      feed_mac(mac_v[k], (k == last_beat), gap_max, poke_busy && (k == 1));
    end
    got_done = 1'b0;
    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      @(posedge clk);
      #1;
      if (stall_at >= 0 && n_drained == stall_at && stall_left > 0 && psum_out_vld) begin
        psum_out_rdy = 1'b0;
        stall_left--;
      end else if (rdy_rand) begin
        psum_out_rdy = ($urandom_range(0, 3) != 0);
      end else begin
        psum_out_rdy = 1'b1;
      end
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    if (!got_done) begin
      fail_now("done_timeout");
    end else begin
      chk("done_busy_low", 64'(busy), 64'(0));
      chk("drained_count", 64'(n_drained), 64'(len));
      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      chk("ovf", 64'(ovf), 64'(exp_ovf));
      chk("err_last", 64'(err_last), 64'(last_beat != len - 1));
      if (poke_done) begin
        send_start(1, 1'b1, 1'b0);
        chk("start_in_done_ignored", 64'(busy), 64'(0));
      end else begin
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
      end
    end
    exp_q.delete();
  endtask

  task automatic rand_vals(input int len, input bit extreme);
    for (int k = 0; k < len; k++) begin
      mac_v[k] = longint'($urandom_range(0, 524287)) - 64'sd262144;
      if (extreme) pre_v[k] = ($urandom_range(0, 1) != 0) ? PMAX - longint'($urandom_range(0, 300000))
                                                         : PMIN + longint'($urandom_range(0, 300000));
      else         pre_v[k] = longint'($urandom_range(0, 8388607)) - 64'sd4194304;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog (simulation time limit)");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_mac_rdy", 64'(mac_rdy), 64'(0));
    chk("rst_psum_in_rdy", 64'(psum_in_rdy), 64'(0));
    chk("rst_out_vld", 64'(psum_out_vld), 64'(0));
    chk("rst_out_data", 64'(psum_out), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_err_last", 64'(err_last), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // First block, len 4, beats 1..4.
    for (int k = 0; k < 4; k++) mac_v[k] = k + 1;
    do_op(4, 1'b1, 1'b0, 3, 0, -1, 1'b0, 1'b0, 1'b0);

    // Preload 10,20,30 then MAC 5,-5,7; also a start poke while busy.
    pre_v[0] = 10; pre_v[1] = 20; pre_v[2] = 30;
    mac_v[0] = 5;  mac_v[1] = -5; mac_v[2] = 7;
    do_op(3, 1'b0, 1'b0, 2, 0, -1, 1'b0, 1'b1, 1'b0);

    // Positive overflow: saturate then wrap; start in the done cycle is ignored.
    pre_v[0] = 4194300; mac_v[0] = 10;
    do_op(1, 1'b0, 1'b1, 0, 0, -1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    pre_v[0] = 4194300; mac_v[0] = 10;
    do_op(1, 1'b0, 1'b0, 0, 0, -1, 1'b0, 1'b0, 1'b0);

    // Negative saturation.
    pre_v[0] = -4194300; pre_v[1] = 0; mac_v[0] = -100; mac_v[1] = -3;
    do_op(2, 1'b0, 1'b1, 1, 0, -1, 1'b0, 1'b0, 1'b0);

    // Full row with input gaps and a 5-cycle drain stall.
    rand_vals(16, 1'b0);
    do_op(16, 1'b0, 1'b1, 15, 2, 8, 1'b0, 1'b0, 1'b0);

    // mac_last early on a 4-beat row.
    for (int k = 0; k < 4; k++) mac_v[k] = 100 * (k + 1);
    do_op(4, 1'b1, 1'b0, 1, 0, -1, 1'b0, 1'b0, 1'b0);

    // cfg_len of 0 behaves as 1.
    pre_v[0] = 77; mac_v[0] = -7;
    do_op(0, 1'b0, 1'b0, 0, 0, -1, 1'b0, 1'b0, 1'b0);

    // Abort during ACC with a reset, then a fresh 2-beat row.
    send_start(8, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) feed_mac(64'sd50, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_mac_rdy", 64'(mac_rdy), 64'(0));
    chk("abort_out_vld", 64'(psum_out_vld), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done), 64'(0));
    end
    mac_v[0] = 9; mac_v[1] = 9;
    do_op(2, 1'b1, 1'b0, 1, 0, -1, 1'b0, 1'b0, 1'b0);

    // Randomised rows.
    for (int r = 0; r < 12; r++) begin
      int  l;
      int  lb;
      bit  f;
      l  = $urandom_range(0, 16);
      f  = $urandom_range(0, 1);
      lb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : ((l == 0) ? 0 : l - 1);
      rand_vals(16, ($urandom_range(0, 1) != 0));
      do_op(l, f, ($urandom_range(0, 1) != 0), lb, 2,
            int'($urandom_range(0, 3)) - 1, 1'b1, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnv_row_acc.md
# cnv_row_acc

Parametrised row partial-sum accumulator for the convolution PE. It receives the chained kernel-tap MAC result for one output pixel per beat and accumulates it into a row of partial sums. The row is optionally preloaded from the previous channel block and streamed out once complete. It generalises the fixed three-tap, fixed-length row accumulator with the following additions:
- runtime row length
- first-block clear mode
- saturating arithmetic
- valid/ready handshakes on every stream

## Interface
Parameters:
- `MAC_WIDTH`, 19: width of the incoming MAC sum (two's complement).
- `PSUM_WIDTH`, 23: partial-sum width; must be ≥ `MAC_WIDTH`.
- `LEN_ROW`, 16: maximum row length (buffer depth).
- `AW`, `$clog2(LEN_ROW)`: address width (derived).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse; latches `cfg_*`. Ignored unless IDLE.
- `cfg_len` in AW+1: row length, 1..`LEN_ROW`. 0 is treated as 1.
- `cfg_first` in 1: 1 = first channel block; buffer is cleared and LOAD is skipped.
- `cfg_sat` in 1: 1 = saturate on overflow; 0 = wrap.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the last drain beat.
- `psum_in_vld` in 1, `psum_in_rdy` out 1, `psum_in` in PSUM_WIDTH: preload stream.
- `mac_vld` in 1, `mac_rdy` out 1, `mac_sum` in MAC_WIDTH, `mac_last` in 1: MAC stream.
- `psum_out_vld` out 1, `psum_out_rdy` in 1, `psum_out` out PSUM_WIDTH, `psum_out_last` out 1: drain stream.
- `ovf` out 1: sticky; set on any saturation or wrap event; cleared by `start`.
- `err_last` out 1: sticky; set when `mac_last` does not match the final beat; cleared by `start`.

## Operation
- FSM states: IDLE, LOAD, ACC, DRAIN.
- IDLE:
  - On `start` with `cfg_first`=1: go to ACC; all buffer entries are treated as 0 (clear happens in the transition cycle).
  - On `start` with `cfg_first`=0: go to LOAD.
  - In both cases `addr` ← `len-1`.
- LOAD:
  - `psum_in_rdy`=1.
  - Each accepted beat writes `buf[addr]`, then `addr` decrements.
  - The beat accepted at `addr`=0 moves to ACC and reloads `addr` ← `len-1`.
- ACC:
  - `mac_rdy`=1.
  - Each accepted beat does `buf[addr]` ← `buf[addr]` + sign-extended `mac_sum`, then `addr` decrements.
  - Pixel order is descending address, matching real feature-map position.
  - The beat at `addr`=0 moves to DRAIN with `addr` ← `len-1`.
  - `mac_last` is expected high exactly on that beat. Any mismatch sets `err_last`; the FSM still advances on the address count only.
- DRAIN:
  - `psum_out` = `buf[addr]`, presented in descending address order.
  - `psum_out_last` = (`addr`==0).
  - On each handshake `addr` decrements. After the last beat: go to IDLE and pulse `done`.
- Arithmetic:
  - Sum is computed at PSUM_WIDTH+1 bits.
  - If `cfg_sat`=1 and the sum overflows, clamp to max or min PSUM_WIDTH signed and set `ovf`.
  - If `cfg_sat`=0, truncate and set `ovf`.
- Entries at addresses ≥ `len` are never read or written during the operation.

## Timing
- Reset values while `rst_n`=0 at a clock edge:
  - state = IDLE, `addr` = `LEN_ROW-1`, all buffer entries = 0.
  - All `rdy`/`vld` outputs, `busy`, `done`, `ovf`, `err_last` = 0.
  - `psum_out` = 0.
- Reset mid-operation aborts immediately. No `done` is produced.
- `start` → `busy`=1 and the first-stage ready asserted on the next cycle.
- LOAD and ACC sustain one beat per cycle. The read-modify-write completes within a single cycle, so back-to-back beats to consecutive addresses need no stall.
- DRAIN:
  - `psum_out_vld` rises the cycle after entering DRAIN.
  - `psum_out`/`psum_out_last` are registered and held stable while `vld`=1 and `rdy`=0.
  - Full throughput when `rdy` stays high.
- `done` is asserted the cycle after the final drain handshake, together with `busy`=0. A `start` in that same cycle is ignored; it is accepted one cycle later.
- `start` while busy is ignored and the config is not relatched.
- `len`=1: each of LOAD, ACC and DRAIN is a single beat, and `psum_out_last` is high on the only beat.
- Minimum total latency with `cfg_first`=1 and no stalls: 1 + `len` + `len` + 1 cycles from `start` to `done`.

## Structure
- Shared package `cnv_pkg`:
  - FSM state enum.
  - `PSUM_WIDTH`/`MAC_WIDTH` defaults.
  - Saturation limit constants.
- Sub-module `psum_sat_add`: combinational signed add with sign extension, saturate/wrap select, and overflow flag. It is reused by other accumulators.
- Buffer is a flop array of `LEN_ROW` × `PSUM_WIDTH`, with a single read and single write port sharing `addr`.

## Test plan
- Reset, then `start` with `cfg_first`=1, `len`=4, MAC beats 1,2,3,4 with `mac_last` on beat 4 → drain 1,2,3,4, `last` on the 4th beat, then `done`; `ovf`=0, `err_last`=0.
- `cfg_first`=0, `len`=3: preload 10,20,30, then MAC 5,−5,7 → drain 15,15,37.
- `cfg_sat`=1, PSUM_WIDTH=23: preload 4194300, then MAC +10 → output 4194303 and `ovf`=1. Repeat with `cfg_sat`=0 → output −4194298 and `ovf`=1.
- `len`=16: random `mac_vld` gaps and `psum_out_rdy` held low for 5 cycles mid-drain → `psum_out` held stable while stalled, all 16 sums correct.
- `mac_last` asserted on beat 2 of a 4-beat row → `err_last`=1; all 4 beats are still consumed and drained.
- `rst_n`=0 during ACC, then `start` with `cfg_first`=1, `len`=2, MAC 9,9 → drain 9,9, with no `done` produced from the aborted operation.
